regfile_bypass: RTL and testbench

- Integer register file for the 5+1 stage RV32 pipeline (IF, ID, EX, MEM, MEM2, WB). It is the consumer end of the wb2rf_bus writeback interface.
- Provides two combinational read ports to ID, with operand forwarding from the EX, MEM and MEM2 bypass buses and the WB bus.
- Generates the load-use stall request toward the pipeline stall controller.

---
 rtl/regfile_bypass.sv | 110 +++++++++++
 tb/tb_regfile_bypass.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// RV32 integer register file with EX/MEM/MEM2/WB operand forwarding and load-use stall detection.
// Optional load-stall performance counter enabled by defining RF_PERF_CNT_EN.
module regfile_bypass #(
  parameter int NREG   = 32,
  parameter int DW     = 32,
  parameter int BYP_WD = 39
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYP_WD-2:0] wb2rf_bus,
  input  logic [BYP_WD-1:0] ex2rf_bus,
  input  logic [BYP_WD-1:0] mem2rf_bus,
  input  logic [BYP_WD-1:0] mem22rf_bus,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  input  logic              ren1,
  input  logic              ren2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2,
  output logic              stallreq_load,
  output logic [31:0]       perf_ldstall_cnt
);

  typedef struct packed {
    logic          is_load;
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
  } byp_t;

  byp_t ex, mem, mem2, wb;

  assign ex   = byp_t'(ex2rf_bus);
  assign mem  = byp_t'(mem2rf_bus);
  assign mem2 = byp_t'(mem22rf_bus);
  assign wb   = byp_t'({1'b0, wb2rf_bus});

  // x0 has no storage; it is hardwired to zero on the read side.
  logic [DW-1:0] regs [1:NREG-1];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the architectural state must be zero after reset, so this array is
      // reset explicitly; that keeps it in flops rather than a RAM macro.
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (wb.we && (wb.waddr != 5'd0)) begin
      regs[wb.waddr] <= wb.wdata;
    end
  end

  function automatic logic hit(input byp_t b, input logic [4:0] a);
    return b.we && (b.waddr == a) && (a != 5'd0);
  endfunction

  // Youngest producer wins; the array is the fallback.
  function automatic logic [DW-1:0] fwd(input logic [4:0] a, input logic [DW-1:0] arr,
                                        input byp_t e, input byp_t m, input byp_t m2,
                                        input byp_t w);
    logic [DW-1:0] d;
    if (a == 5'd0)       d = '0;
    else if (hit(e, a))  d = e.wdata;
    else if (hit(m, a))  d = m.wdata;
    else if (hit(m2, a)) d = m2.wdata;
    else if (hit(w, a))  d = w.wdata;
    else                 d = arr;
    return d;
  endfunction

  // A younger non-load producer in EX shadows an older load in MEM.
  // MEM2 loads never stall because their data is already valid there.
  function automatic logic hazard(input logic [4:0] a, input byp_t e, input byp_t m);
    logic h;
    if (hit(e, a)) h = e.is_load;
    else           h = hit(m, a) && m.is_load;
    return h;
  endfunction

  logic [DW-1:0] arr1, arr2;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    arr1 = '0;
    arr2 = '0;
    if (raddr1 != 5'd0) arr1 = regs[raddr1];
    if (raddr2 != 5'd0) arr2 = regs[raddr2];
  end

  assign rdata1 = fwd(raddr1, arr1, ex, mem, mem2, wb);
  assign rdata2 = fwd(raddr2, arr2, ex, mem, mem2, wb);

  assign stallreq_load = (ren1 && hazard(raddr1, ex, mem)) ||
                         (ren2 && hazard(raddr2, ex, mem));

`ifdef RF_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)             perf_cnt <= '0;
    else if (stallreq_load) perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_ldstall_cnt = perf_cnt;
`else
  assign perf_ldstall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: stimulus pushes expected read/stall results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [37:0] wb2rf_bus;
  logic [38:0] ex2rf_bus, mem2rf_bus, mem22rf_bus;
  logic [4:0]  raddr1, raddr2;
  logic        ren1, ren2;
  logic [31:0] rdata1, rdata2;
  logic        stallreq_load;
  logic [31:0] perf_ldstall_cnt;

  regfile_bypass dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb2rf_bus        (wb2rf_bus),
    .ex2rf_bus        (ex2rf_bus),
    .mem2rf_bus       (mem2rf_bus),
    .mem22rf_bus      (mem22rf_bus),
    .raddr1           (raddr1),
    .raddr2           (raddr2),
    .ren1             (ren1),
    .ren2             (ren2),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .stallreq_load    (stallreq_load),
    .perf_ldstall_cnt (perf_ldstall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        c1;
    logic [31:0] d1;
    logic        c2;
    logic [31:0] d2;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  logic        exp_stall_now = 1'b0;
  logic [31:0] exp_cnt = 32'h0;

  // Expected counter: advances on cycles the stimulus declared as stalling.
  always @(posedge clk) begin
    if (!rst_n)             exp_cnt <= 32'h0;
    else if (exp_stall_now) exp_cnt <= exp_cnt + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: everything pushed since the last negedge describes the current inputs.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.c1) check({n, ".rdata1"}, rdata1, e.d1);
        if (e.c2) check({n, ".rdata2"}, rdata2, e.d2);
        check({n, ".stall"}, {31'b0, stallreq_load}, {31'b0, e.st});
        check({n, ".perf"}, perf_ldstall_cnt, e.cnt);
      end
    end
  end

  function automatic logic [38:0] byp(input logic ld, input logic [4:0] a, input logic [31:0] d);
    return {ld, 1'b1, a, d};
  endfunction

  function automatic logic [37:0] wbw(input logic [4:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic idle();
    wb2rf_bus = '0; ex2rf_bus = '0; mem2rf_bus = '0; mem22rf_bus = '0;
    raddr1 = '0; raddr2 = '0; ren1 = 1'b0; ren2 = 1'b0;
    exp_stall_now = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic c1, input logic [31:0] d1,
                           input logic c2, input logic [31:0] d2, input logic st);
    exp_t e;
    exp_stall_now = st;
    e.c1 = c1; e.d1 = d1; e.c2 = c2; e.d2 = d2; e.st = st;
`ifdef RF_PERF_CNT_EN
    e.cnt = exp_cnt;
`else
    e.cnt = 32'h0;
`endif
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    step(); step();
    expect_rd("in_reset", 1, 32'h0, 1, 32'h0, 0);
    step();
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i); ren1 = 1'b1; ren2 = 1'b1;
      expect_rd("reset_zero", 1, 32'h0, 1, 32'h0, 0);
      step();
    end

    idle();
    wb2rf_bus = wbw(5, 32'hDEADBEEF); raddr1 = 5;
    expect_rd("wb_thru_x5", 1, 32'hDEADBEEF, 0, 0, 0);
    step();
    idle(); raddr2 = 5;
    expect_rd("array_x5", 0, 0, 1, 32'hDEADBEEF, 0);
    step();

    idle();
    wb2rf_bus = wbw(0, 32'h12345678);
    ex2rf_bus = byp(1, 0, 32'h12345678); mem2rf_bus = byp(1, 0, 32'h12345678);
    mem22rf_bus = byp(0, 0, 32'h12345678);
    ren1 = 1; ren2 = 1;
    expect_rd("x0_buses", 1, 32'h0, 1, 32'h0, 0);
    step();
    idle(); ren1 = 1;
    expect_rd("x0_after", 1, 32'h0, 1, 32'h0, 0);
    step();

    idle();
    wb2rf_bus = wbw(7, 32'hA5A5A5A5); raddr1 = 7;
    expect_rd("wb_thru_x7", 1, 32'hA5A5A5A5, 0, 0, 0);
    step();
    idle(); raddr1 = 7;
    expect_rd("array_x7", 1, 32'hA5A5A5A5, 0, 0, 0);
    step();
    wb2rf_bus = wbw(7, 32'h5A5A5A5A); ex2rf_bus = byp(0, 7, 32'h11);
    mem2rf_bus = byp(0, 7, 32'h22); mem22rf_bus = byp(0, 7, 32'h33); raddr2 = 5;
    expect_rd("prio_ex", 1, 32'h11, 1, 32'hDEADBEEF, 0);
    step();
    ex2rf_bus = '0;
    expect_rd("prio_mem", 1, 32'h22, 0, 0, 0);
    step();
    mem2rf_bus = '0;
    expect_rd("prio_mem2", 1, 32'h33, 0, 0, 0);
    step();
    mem22rf_bus = '0; wb2rf_bus = wbw(7, 32'h0F0F0F0F);
    expect_rd("prio_wb", 1, 32'h0F0F0F0F, 0, 0, 0);
    step();
    idle(); raddr1 = 7;
    expect_rd("array_x7_new", 1, 32'h0F0F0F0F, 0, 0, 0);
    step();
    ex2rf_bus = byp(0, 10, 32'hAAAA0001); mem2rf_bus = byp(0, 11, 32'hBBBB0002);
    raddr1 = 10; raddr2 = 11;
    expect_rd("indep_ports", 1, 32'hAAAA0001, 1, 32'hBBBB0002, 0);
    step();

    idle();
    ex2rf_bus = byp(1, 9, 32'h00000099); raddr2 = 9; ren2 = 1;
    expect_rd("ld_ex_stall", 0, 0, 1, 32'h00000099, 1);
    step();
    ren2 = 0;
    expect_rd("ld_ex_ren0", 0, 0, 1, 32'h00000099, 0);
    step();
    ren2 = 1; raddr2 = 8;
    expect_rd("ld_ex_other", 0, 0, 0, 0, 0);
    step();
    raddr2 = 0; raddr1 = 9; ren1 = 1;
    expect_rd("ld_ex_port1", 1, 32'h00000099, 0, 0, 1);
    step();
    idle();
    mem2rf_bus = byp(1, 9, 32'h00000077); raddr2 = 9; ren2 = 1;
    expect_rd("ld_mem_stall", 0, 0, 0, 0, 1);
    step();
    idle();
    mem22rf_bus = byp(1, 9, 32'hCAFEF00D); raddr2 = 9; ren2 = 1;
    expect_rd("ld_mem2", 0, 0, 1, 32'hCAFEF00D, 0);
    step();
    idle();
    ex2rf_bus = byp(0, 9, 32'h00000055); mem2rf_bus = byp(1, 9, 32'h00000077);
    raddr2 = 9; ren2 = 1;
    expect_rd("shadow", 0, 0, 1, 32'h00000055, 0);
    step();

    idle();
    ex2rf_bus = byp(1, 12, 32'h0); raddr1 = 12; ren1 = 1;
    for (int i = 0; i < 5; i++) begin
      expect_rd("stall_run", 0, 0, 0, 0, 1);
      step();
    end
    idle();
    expect_rd("stall_run_end", 0, 0, 0, 0, 0);
    step();

    for (int i = 1; i <= 3; i++) begin
      idle(); wb2rf_bus = wbw(5'(i), 32'(i));
      step();
    end
    idle(); raddr1 = 2; raddr2 = 3;
    expect_rd("pre_reset", 1, 32'h2, 1, 32'h3, 0);
    step();
    rst_n = 1'b0; wb2rf_bus = wbw(2, 32'hFF);
    step();
    rst_n = 1'b1; idle(); raddr1 = 2; raddr2 = 1;
    expect_rd("post_reset", 1, 32'h0, 1, 32'h0, 0);
    step();
    raddr1 = 3;
    expect_rd("post_reset_x3", 1, 32'h0, 0, 0, 0);
    step();

`ifdef RF_PERF_CNT_EN
    idle();
    force dut.perf_cnt = 32'hFFFFFFFF;
    step();
    release dut.perf_cnt;
    exp_cnt = 32'hFFFFFFFF;
    ex2rf_bus = byp(1, 4, 32'h0); raddr1 = 4; ren1 = 1;
    expect_rd("cnt_max", 0, 0, 0, 0, 1);
    step();
    expect_rd("cnt_wrap", 0, 0, 0, 0, 1);
    step();
    idle();
`endif

    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
